// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences FETCH/DECODE/EXEC/MEM/WB from the
// latched IR opcode and drives the datapath/memory strobes plus the 2-bit ALU-op
// code for the ALU control unit. Stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode[5:0]       IR[31:26], stable from DECODE until return to FETCH
//   mem_ready         memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0]    combinational strobes decoded from state (+mem_ready)
//   illegal_op        sticky flag, set when DECODE sees an unknown opcode
//   state[3:0]        current state (debug)
module main_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned SW = 4;
  localparam int unsigned OW = 6;

  localparam logic [OW-1:0] OP_R    = 6'b000000;
  localparam logic [OW-1:0] OP_LW   = 6'b100011;
  localparam logic [OW-1:0] OP_SW   = 6'b101011;
  localparam logic [OW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OW-1:0] OP_ANDI = 6'b001100;
  localparam logic [OW-1:0] OP_J    = 6'b000010;

  localparam logic [SW-1:0] S_IDLE      = 4'd0;
  localparam logic [SW-1:0] S_FETCH     = 4'd1;
  localparam logic [SW-1:0] S_DECODE    = 4'd2;
  localparam logic [SW-1:0] S_MEM_ADDR  = 4'd3;
  localparam logic [SW-1:0] S_MEM_READ  = 4'd4;
  localparam logic [SW-1:0] S_MEM_WB    = 4'd5;
  localparam logic [SW-1:0] S_MEM_WRITE = 4'd6;
  localparam logic [SW-1:0] S_R_EXEC    = 4'd7;
  localparam logic [SW-1:0] S_R_WB      = 4'd8;
  localparam logic [SW-1:0] S_BRANCH    = 4'd9;
  localparam logic [SW-1:0] S_JUMP      = 4'd10;
  localparam logic [SW-1:0] S_I_EXEC    = 4'd11;
  localparam logic [SW-1:0] S_I_WB      = 4'd12;

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          bad_opcode_c;

  assign state = state_q;

  // Opcode not in the supported instruction set
  always_comb begin
    bad_opcode_c = 1'b1;
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_J: bad_opcode_c = 1'b0;
      default:                                            bad_opcode_c = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sticky illegal-opcode flag, only cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    illegal_op <= 1'b0;
    else if ((state_q == S_DECODE) && bad_opcode_c) illegal_op <= 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      // Unused encodings 13-15 recover through FETCH
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode; every strobe defaults to 0
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR latch and PC+4 commit only in the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_I_WB: begin
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
